// File: rtl/console_uart_tx.sv
// console_uart_tx: snoops dmem byte stores to TX_ADDR, queues them, sends each as an 8N1 frame.
// Latency: store at edge k -> FIFO at k, popped at k+1, start bit on tx after k+1; frame = 10*CLKS_PER_BIT.
// Backpressure: none toward the pipeline; a store while full (and no same-cycle pop) is dropped, sets overflow.
// Ports:
//   clock, clear       core clock, synchronous active-high reset
//   wren, addr, din    MEM-stage store snoop (only din[7:0] carried)
//   tx                 serial line, idle high, registered
//   busy, full         frame in progress or FIFO non-empty / FIFO at capacity
//   overflow, count    sticky drop flag / FIFO occupancy 0..FIFO_DEPTH
module console_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [7:0]  TX_ADDR      = 8'hFF
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic                          wren,
  input  logic [7:0]                    addr,
  input  logic [31:0]                   din,
  output logic                          tx,
  output logic                          busy,
  output logic                          full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [BAUD_W-1:0] baudCnt;
  logic [2:0]        bitIdx;
  logic [7:0]        shiftReg;
  logic              txReg;

  logic [7:0]        fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  cnt;
  logic              ovfReg;

  logic push;
  logic pop;
  logic pushAccept;
  logic notEmpty;
  logic isFull;
  logic baudDone;
  logic unusedDinHi;

  // Upper store bits are never part of a console byte.
  assign unusedDinHi = ^din[31:8];

  assign push     = wren && (addr == TX_ADDR);
  assign notEmpty = (cnt != '0);
  assign isFull   = (cnt == CNT_W'(FIFO_DEPTH));
  assign baudDone = (baudCnt == BAUD_W'(CLKS_PER_BIT - 1));

  // Pops come only from the FSM: when idle, or at the last cycle of a stop bit
  // so the next start bit follows without an idle gap.
  assign pop = notEmpty && ((state == IDLE) || ((state == STOP) && baudDone));

  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign pushAccept = push && (!isFull || pop);

  // Storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clock) begin
    if (pushAccept) begin
      fifoMem[wrPtr] <= din[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      cnt    <= '0;
      ovfReg <= 1'b0;
    end else begin
      if (pushAccept) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (pushAccept && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !pushAccept) begin
        cnt <= cnt - 1'b1;
      end
      if (push && !pushAccept) begin
        ovfReg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txReg    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txReg   <= 1'b1;
          baudCnt <= '0;
          if (pop) begin
            shiftReg <= fifoMem[rdPtr];
            txReg    <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baudDone) begin
            baudCnt <= '0;
            bitIdx  <= '0;
            txReg   <= shiftReg[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        DATA: begin
          if (baudDone) begin
            baudCnt <= '0;
            if (bitIdx == 3'd7) begin
              txReg <= 1'b1;
              state <= STOP;
            end else begin
              bitIdx   <= bitIdx + 1'b1;
              shiftReg <= shiftReg >> 1;
              // Next bit is shiftReg[1] because the shift lands this same edge.
              txReg    <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        STOP: begin
          if (baudDone) begin
            baudCnt <= '0;
            if (pop) begin
              shiftReg <= fifoMem[rdPtr];
              txReg    <= 1'b0;
              state    <= START;
            end else begin
              txReg <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        default: begin
          txReg <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign tx       = txReg;
  assign busy     = (state != IDLE) || notEmpty;
  assign full     = isFull;
  assign overflow = ovfReg;
  assign count    = cnt;

endmodule

// File: tb/tb_console_uart_tx.sv
// tb_console_uart_tx: directed stimulus for console_uart_tx with a serial-frame monitor and byte scoreboard.
// Latency: checks start bit one cycle after the push edge and 160-cycle frames at CLKS_PER_BIT=16.
// Backpressure: exercises FIFO-full drop and sticky overflow.
module tb_console_uart_tx;

  logic        clock;
  logic        clear;
  logic        wren;
  logic [7:0]  addr;
  logic [31:0] din;
  logic        tx;
  logic        busy;
  logic        full;
  logic        overflow;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit monEn = 1'b1;

  logic [7:0] sb[$];
  int         startQ[$];

  console_uart_tx #(
    .CLKS_PER_BIT(16),
    .FIFO_DEPTH  (8),
    .TX_ADDR     (8'hFF)
  ) dut (
    .clock   (clock),
    .clear   (clear),
    .wren    (wren),
    .addr    (addr),
    .din     (din),
    .tx      (tx),
    .busy    (busy),
    .full    (full),
    .overflow(overflow),
    .count   (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of bus activity; returns at the negedge after the sampling edge.
  task automatic drive(input logic w, input logic [7:0] a, input logic [31:0] d);
    wren = w;
    addr = a;
    din  = d;
    @(negedge clock);
  endtask

  // Frame monitor: samples mid-bit, compares each byte against the scoreboard.
  initial begin : monitor
    logic [7:0] rx;
    logic [7:0] expByte;
    forever begin
      @(negedge clock);
      if (monEn && tx === 1'b0) begin
        startQ.push_back(cyc);
        rx = '0;
        repeat (8) @(negedge clock);
        check("start_bit", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clock);
          rx[i] = tx;
        end
        repeat (16) @(negedge clock);
        check("stop_bit", {31'd0, tx}, 32'd1);
        check("frame_expected", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          expByte = sb.pop_front();
          check("rx_byte", {24'd0, rx}, {24'd0, expByte});
        end
        repeat (7) @(negedge clock);
      end
    end
  end

  initial begin : stim
    int busyFall;
    int txLowCnt;

    clear = 1'b1;
    wren  = 1'b0;
    addr  = 8'h00;
    din   = 32'h0;
    @(negedge clock);

    // T1 reset
    drive(1'b0, 8'h00, 32'h0);
    drive(1'b0, 8'h00, 32'h0);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    clear = 1'b0;
    drive(1'b0, 8'h00, 32'h0);

    // T2 single byte 'A'
    sb.push_back(8'h41);
    drive(1'b1, 8'hFF, 32'h0000_0041);
    check("t2_count_after_push", {28'd0, count}, 32'd1);
    check("t2_tx_still_idle", {31'd0, tx}, 32'd1);
    drive(1'b0, 8'h00, 32'h0);
    check("t2_tx_start", {31'd0, tx}, 32'd0);
    check("t2_count_after_pop", {28'd0, count}, 32'd0);
    check("t2_busy_start", {31'd0, busy}, 32'd1);
    repeat (159) drive(1'b0, 8'h00, 32'h0);
    check("t2_busy_at_159", {31'd0, busy}, 32'd1);
    check("t2_stop_high", {31'd0, tx}, 32'd1);
    drive(1'b0, 8'h00, 32'h0);
    check("t2_busy_fall_160", {31'd0, busy}, 32'd0);
    repeat (10) drive(1'b0, 8'h00, 32'h0);
    check("t2_sb_drained", sb.size(), 32'd0);

    // T3 address filter
    drive(1'b1, 8'hFE, 32'h0000_0055);
    check("t3_count", {28'd0, count}, 32'd0);
    drive(1'b0, 8'h00, 32'h0);
    check("t3_tx", {31'd0, tx}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);

    // T4 back-to-back "Hi"
    startQ.delete();
    sb.push_back(8'h48);
    sb.push_back(8'h69);
    drive(1'b1, 8'hFF, 32'h0000_0048);
    drive(1'b1, 8'hFF, 32'h0000_0069);
    wren = 1'b0;
    for (int i = 0; i < 1000 && busy !== 1'b0; i++) @(negedge clock);
    busyFall = cyc;
    check("t4_busy_low", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge clock);
    check("t4_frames", startQ.size(), 32'd2);
    if (startQ.size() >= 2) begin
      check("t4_gapless", startQ[1] - startQ[0], 32'd160);
      check("t4_total_320", busyFall - startQ[0], 32'd320);
    end
    check("t4_sb_drained", sb.size(), 32'd0);

    // T5 overflow: 10 consecutive pushes, the 10th is dropped
    for (int i = 0; i < 9; i++) begin
      sb.push_back(8'h30 + 8'(i));
      drive(1'b1, 8'hFF, {24'd0, 8'h30 + 8'(i)});
    end
    check("t5_full_before_drop", {31'd0, full}, 32'd1);
    check("t5_count_8", {28'd0, count}, 32'd8);
    check("t5_no_overflow_yet", {31'd0, overflow}, 32'd0);
    drive(1'b1, 8'hFF, 32'h0000_0039);
    wren = 1'b0;
    check("t5_overflow_set", {31'd0, overflow}, 32'd1);
    check("t5_count_still_8", {28'd0, count}, 32'd8);
    for (int i = 0; i < 3000 && (busy !== 1'b0 || sb.size() != 0); i++) @(negedge clock);
    check("t5_drained", sb.size(), 32'd0);
    check("t5_idle", {31'd0, busy}, 32'd0);
    check("t5_overflow_sticky", {31'd0, overflow}, 32'd1);
    repeat (10) @(negedge clock);

    // T6 reset during DATA bit 3 of 8'hA5, with a second byte queued
    monEn = 1'b0;
    drive(1'b1, 8'hFF, 32'h0000_00A5);
    drive(1'b1, 8'hFF, 32'h0000_005A);
    repeat (68) drive(1'b0, 8'h00, 32'h0);
    check("t6_bit3_low", {31'd0, tx}, 32'd0);
    check("t6_queued", {28'd0, count}, 32'd1);
    clear = 1'b1;
    drive(1'b0, 8'h00, 32'h0);
    check("t6_tx_high", {31'd0, tx}, 32'd1);
    check("t6_count", {28'd0, count}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_overflow_cleared", {31'd0, overflow}, 32'd0);
    clear = 1'b0;
    txLowCnt = 0;
    for (int i = 0; i < 400; i++) begin
      drive(1'b0, 8'h00, 32'h0);
      if (tx !== 1'b1) txLowCnt++;
    end
    check("t6_no_more_frames", txLowCnt, 32'd0);
    check("t6_still_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
